writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Writeback stage directly upstream of the register file write port. Merges single-cycle
//  ALU results with long-latency load/mul results (LSU path, buffered in a small FIFO) onto
//  the single write port (waddr/wdata/wren/is_upper). Keeps a pending-write scoreboard for
//  issue-stage hazard checks. Bypasses the in-flight write onto both read ports.
// PARAMETERS
//  LSU_DEPTH     2  LSU result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  4  cycles a FIFO head may lose to the ALU before alu_stall asserts (>=1)
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   synchronous, active-high reset
//  alu_valid    in   1   ALU result present this cycle (no backpressure except alu_stall)
//  alu_waddr    in   5   ALU destination register
//  alu_wdata    in   32  ALU result
//  alu_is_upper in   1   result is an upper-immediate (regfile stores wdata<<16)
//  alu_stall    out  1   ALU must hold; alu_valid must be 0 while high
//  lsu_valid    in   1   LSU result offered
//  lsu_ready    out  1   FIFO can accept; transfer on lsu_valid&&lsu_ready
//  lsu_waddr    in   5   LSU destination register
//  lsu_wdata    in   32  LSU result (is_upper is always 0 on this path)
//  issue_valid  in   1   instruction issued this cycle
//  issue_long   in   1   issued instruction completes on the LSU path
//  issue_rd     in   5   its destination register
//  raddr0/1     in   5   register file read addresses (shared with register file)
//  rf_rdata0/1  in   32  raw register file read data
//  rdata0/1     out  32  bypassed read data
//  busy0/1      out  1   raddr0/1 has a pending long write
//  waddr        out  5   register file write address
//  wdata        out  32  register file write data
//  wren         out  1   register file write enable
//  is_upper     out  1   register file upper-immediate select
// BEHAVIOUR
//  Reset: wren=0, is_upper=0, waddr=0, wdata=0, FIFO empty, lsu_ready=1, scoreboard clear,
//   starve counter 0, alu_stall=0. Reset mid-operation drops all queued LSU results.
//  Arbitration each cycle (select S): alu_stall=1 -> FIFO head; else alu_valid -> ALU;
//   else FIFO non-empty -> FIFO head; else none. Selected FIFO head pops this cycle.
//  Write stage: S registered on posedge -> wren/waddr/wdata/is_upper; latency exactly 1.
//   Selection with waddr==0 still pops/clears but drives wren=0 (r0 never written).
//  FIFO: push on lsu_valid&&lsu_ready; lsu_ready = (count<LSU_DEPTH) combinational from
//   count only (no same-cycle pop-through). Simultaneous push+pop keeps count. Pointers wrap.
//  Starvation: counter +1 each cycle FIFO non-empty and head not selected; cleared on pop or
//   empty; saturates at STARVE_LIMIT. alu_stall = (counter==STARVE_LIMIT) combinational.
//   alu_valid while alu_stall=1 is a protocol violation (bench assertion).
//  Scoreboard: 32 bits. Set on issue_valid&&issue_long&&issue_rd!=0 at posedge; cleared at
//   the posedge that loads a FIFO head into the write stage. Same-edge set+clear of same
//   register: set wins. busyN = pending[raddrN]; raddrN==0 -> busyN=0.
//  Bypass: fwd = is_upper ? wdata<<16 : wdata. rdataN = (wren && waddr==raddrN) ? fwd
//   : rf_rdataN (wren=0 when waddr==0, so r0 never bypassed).
// TESTING
//  1 ALU r5, wdata 0x00001234, is_upper=1 -> next cycle wren=1 waddr=5 is_upper=1;
//    raddr0=5 that cycle -> rdata0=0x12340000 while rf_rdata0 is stale.
//  2 issue_long rd=7 -> busy0=1 (raddr0=7) from next cycle; LSU r7=0xDEADBEEF -> busy0=0
//    in the cycle wren=1 waddr=7, rdata0=0xDEADBEEF same cycle.
//  3 ALU r3 and LSU r4 same cycle, FIFO empty -> wren r3 at T+1, r4 at T+2.
//  4 ALU valid every cycle, one LSU entry queued -> alu_stall=1 after 4 losing cycles,
//    LSU entry written next, alu_stall=0 the cycle after pop.
//  5 Three back-to-back LSU offers under ALU pressure -> 2 accepted, lsu_ready=0 on 3rd;
//    write to r0 from either path -> wren stays 0; rst with FIFO full -> all outputs reset.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and buffered LSU results onto one regfile
// write port; tracks pending long writes and bypasses the in-flight write.
// Ports: ALU result in (+alu_stall), LSU valid/ready in, issue tracking,
// two read ports (raddr/rf_rdata in, rdata/busy out), regfile write out.
module writeback_arbiter #(
  parameter int LSU_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  input  logic        alu_is_upper,
  output logic        alu_stall,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_waddr,
  input  logic [31:0] lsu_wdata,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  raddr0,
  input  logic [4:0]  raddr1,
  input  logic [31:0] rf_rdata0,
  input  logic [31:0] rf_rdata1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        busy0,
  output logic        busy1,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        wren,
  output logic        is_upper
);

  localparam int PW = $clog2(LSU_DEPTH);
  localparam int CW = $clog2(LSU_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_fifo_addr [LSU_DEPTH];
  logic [31:0]   r_fifo_data [LSU_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic [31:0]   r_pending;
  logic          r_wren;
  logic [4:0]    r_waddr;
  logic [31:0]   r_wdata;
  logic          r_is_upper;

  logic          w_empty;
  logic          w_push;
  logic          w_sel_fifo;
  logic          w_sel_alu;
  logic          w_sel_any;
  logic [4:0]    w_sel_addr;
  logic [31:0]   w_sel_data;
  logic          w_sel_up;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;
  logic [31:0]   w_fwd;

  assign w_empty     = (r_count == '0);
  assign lsu_ready   = (r_count < CW'(LSU_DEPTH));
  assign alu_stall   = (r_starve == SW'(STARVE_LIMIT));
  assign w_push      = lsu_valid && lsu_ready;
  assign w_head_addr = r_fifo_addr[r_rptr];

  // Stall implies a non-empty FIFO, so the two selects never overlap.
  assign w_sel_fifo = !w_empty && (alu_stall || !alu_valid);
  assign w_sel_alu  = !alu_stall && alu_valid;
  assign w_sel_any  = w_sel_fifo || w_sel_alu;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_up   = 1'b0;
    unique case (1'b1)
      w_sel_fifo: begin
        w_sel_addr = w_head_addr;
        w_sel_data = r_fifo_data[r_rptr];
      end
      w_sel_alu: begin
        w_sel_addr = alu_waddr;
        w_sel_data = alu_wdata;
        w_sel_up   = alu_is_upper;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= lsu_waddr;
      r_fifo_data[r_wptr] <= lsu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_sel_fifo)
        r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_sel_fifo)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_sel_fifo)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_starve <= '0;
    else if (w_empty || w_sel_fifo)
      r_starve <= '0;
    else if (!alu_stall)
      r_starve <= r_starve + SW'(1);
  end

  // Set is applied after clear so a same-edge re-issue stays pending.
  assign w_set = (issue_valid && issue_long && issue_rd != 5'd0)
               ? (32'd1 << issue_rd) : 32'd0;
  assign w_clr = w_sel_fifo ? (32'd1 << w_head_addr) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst)
      r_pending <= '0;
    else
      r_pending <= (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wren     <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_is_upper <= 1'b0;
    end else begin
      r_wren <= w_sel_any && (w_sel_addr != 5'd0);
      if (w_sel_any) begin
        r_waddr    <= w_sel_addr;
        r_wdata    <= w_sel_data;
        r_is_upper <= w_sel_up;
      end
    end
  end

  assign wren     = r_wren;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign is_upper = r_is_upper;

  assign w_fwd  = r_is_upper ? {r_wdata[15:0], 16'h0000} : r_wdata;
  assign rdata0 = (r_wren && r_waddr == raddr0) ? w_fwd : rf_rdata0;
  assign rdata1 = (r_wren && r_waddr == raddr1) ? w_fwd : rf_rdata1;
  assign busy0  = (raddr0 != 5'd0) && r_pending[raddr0];
  assign busy1  = (raddr1 != 5'd0) && r_pending[raddr1];

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random stimulus against a queue-based
// reference model; a separate monitor pops expected writes as wren appears.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_is_upper, alu_stall;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        issue_valid, issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  raddr0, raddr1;
  logic [31:0] rf_rdata0, rf_rdata1, rdata0, rdata1;
  logic        busy0, busy1;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wren, is_upper;

  writeback_arbiter #(.LSU_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr),
    .alu_wdata(alu_wdata), .alu_is_upper(alu_is_upper),
    .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .issue_rd(issue_rd),
    .raddr0(raddr0), .raddr1(raddr1),
    .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .rdata0(rdata0), .rdata1(rdata1),
    .busy0(busy0), .busy1(busy1),
    .waddr(waddr), .wdata(wdata), .wren(wren), .is_upper(is_upper)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        up;
  } wr_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, pending set as a bit array.
  wr_t       m_q[$];
  wr_t       exp_q[$];
  int        m_starve = 0;
  bit [31:0] m_pend   = '0;
  bit        m_wv     = 0;
  bit [4:0]  m_wa     = '0;
  bit [31:0] m_fwd    = '0;
  bit        m_live   = 0;
  bit        m_just_rst = 0;

  function automatic logic [31:0] ref_rd(input logic [4:0] ra,
                                         input logic [31:0] rf);
    return (m_wv && m_wa == ra) ? m_fwd : rf;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    bit  have, popped, empty_pre, ready_pre, stall;
    if (m_live) begin
      chk("lsu_ready", 32'(lsu_ready), 32'(m_q.size() < 2));
      chk("alu_stall", 32'(alu_stall), 32'(m_starve == 4));
      chk("wren", 32'(wren), 32'(m_wv));
      chk("busy0", 32'(busy0), 32'(raddr0 != 0 && m_pend[raddr0]));
      chk("busy1", 32'(busy1), 32'(raddr1 != 0 && m_pend[raddr1]));
      chk("rdata0", rdata0, ref_rd(raddr0, rf_rdata0));
      chk("rdata1", rdata1, ref_rd(raddr1, rf_rdata1));
      if (m_just_rst) begin
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_is_upper", 32'(is_upper), 32'd0);
      end
    end
    m_just_rst = 0;
    if (rst) begin
      m_q.delete();
      m_starve   = 0;
      m_pend     = '0;
      m_wv       = 0;
      m_live     = 1;
      m_just_rst = 1;
    end else if (m_live) begin
      stall     = (m_starve == 4);
      empty_pre = (m_q.size() == 0);
      ready_pre = (m_q.size() < 2);
      have   = 0;
      popped = 0;
      if (!empty_pre && (stall || !alu_valid)) begin
        e = m_q.pop_front();
        have   = 1;
        popped = 1;
        m_pend[e.a] = 0;
      end else if (alu_valid) begin
        e.a  = alu_waddr;
        e.d  = alu_wdata;
        e.up = alu_is_upper;
        have = 1;
      end
      if (issue_valid && issue_long && issue_rd != 0)
        m_pend[issue_rd] = 1;
      m_wv = have && (e.a != 0);
      if (m_wv) begin
        m_wa  = e.a;
        m_fwd = e.up ? (e.d << 16) : e.d;
        exp_q.push_back(e);
      end
      if (lsu_valid && ready_pre) begin
        e.a  = lsu_waddr;
        e.d  = lsu_wdata;
        e.up = 1'b0;
        m_q.push_back(e);
      end
      if (empty_pre || popped)
        m_starve = 0;
      else if (m_starve < 4)
        m_starve = m_starve + 1;
    end
  end

  // Monitor: every regfile write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (m_live && wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write waddr=%0d wdata=%h t=%0t",
                 waddr, wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("mon_waddr", 32'(waddr), 32'(e.a));
        chk("mon_wdata", wdata, e.d);
        chk("mon_is_upper", 32'(is_upper), 32'(e.up));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0)
      assert (!(alu_stall === 1'b1 && alu_valid === 1'b1))
      else begin
        failures++;
        $display("FAIL alu_valid_during_stall t=%0t", $time);
      end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rst         = 1'b0;
    alu_valid   = 1'b0;
    lsu_valid   = 1'b0;
    issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_waddr = '0; alu_wdata = '0; alu_is_upper = 0;
    lsu_valid = 0; lsu_waddr = '0; lsu_wdata = '0;
    issue_valid = 0; issue_long = 0; issue_rd = '0;
    raddr0 = '0; raddr1 = '0; rf_rdata0 = '0; rf_rdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    idle();

    // Upper-immediate ALU write and bypass.
    tick(); idle();
    alu_valid = 1; alu_waddr = 5'd5; alu_wdata = 32'h1234; alu_is_upper = 1;
    tick(); idle();
    alu_is_upper = 0;
    raddr0 = 5'd5; rf_rdata0 = 32'hAAAA5555;
    @(negedge clk);
    chk("t1_wren", 32'(wren), 32'd1);
    chk("t1_waddr", 32'(waddr), 32'd5);
    chk("t1_rdata0", rdata0, 32'h12340000);

    // Long write tracking.
    tick(); idle();
    issue_valid = 1; issue_long = 1; issue_rd = 5'd7;
    tick(); idle();
    raddr0 = 5'd7;
    @(negedge clk);
    chk("t2_busy_set", 32'(busy0), 32'd1);
    tick(); idle();
    lsu_valid = 1; lsu_waddr = 5'd7; lsu_wdata = 32'hDEADBEEF;
    tick(); idle();
    @(negedge clk);
    chk("t2_busy_held", 32'(busy0), 32'd1);
    tick(); idle();
    @(negedge clk);
    chk("t2_wren", 32'(wren), 32'd1);
    chk("t2_waddr", 32'(waddr), 32'd7);
    chk("t2_busy_clr", 32'(busy0), 32'd0);
    chk("t2_rdata0", rdata0, 32'hDEADBEEF);

    // Same-cycle ALU and LSU.
    tick(); idle();
    alu_valid = 1; alu_waddr = 5'd3; alu_wdata = 32'd3;
    lsu_valid = 1; lsu_waddr = 5'd4; lsu_wdata = 32'd4;
    tick(); idle();
    @(negedge clk);
    chk("t3_first", 32'(waddr), 32'd3);
    tick(); idle();
    @(negedge clk);
    chk("t3_second", 32'(waddr), 32'd4);
    chk("t3_wren", 32'(wren), 32'd1);

    // Starvation under constant ALU pressure.
    tick(); idle();
    alu_valid = 1; alu_waddr = 5'd1; alu_wdata = 32'd11;
    lsu_valid = 1; lsu_waddr = 5'd9; lsu_wdata = 32'h99;
    for (int k = 1; k <= 5; k++) begin
      tick(); idle();
      alu_valid = (m_starve != 4);
      alu_waddr = 5'(k + 1);
      alu_wdata = 32'(k);
      @(negedge clk);
      chk("t4_stall", 32'(alu_stall), 32'(k == 5));
    end
    tick(); idle();
    alu_valid = 1; alu_waddr = 5'd20; alu_wdata = 32'd20;
    @(negedge clk);
    chk("t4_lsu_waddr", 32'(waddr), 32'd9);
    chk("t4_stall_clr", 32'(alu_stall), 32'd0);

    // FIFO full, r0 writes, reset while full.
    for (int k = 0; k < 3; k++) begin
      tick(); idle();
      alu_valid = 1; alu_waddr = 5'(10 + k); alu_wdata = 32'(k);
      lsu_valid = 1; lsu_waddr = 5'(12 + k); lsu_wdata = 32'(k + 100);
      @(negedge clk);
      chk("t5_ready", 32'(lsu_ready), 32'(k < 2));
    end
    tick(); idle();
    alu_valid = 1; alu_waddr = 5'd0; alu_wdata = 32'h77;
    tick(); idle();
    rst = 1;
    @(negedge clk);
    chk("t5_r0_alu", 32'(wren), 32'd0);
    tick(); idle();
    @(negedge clk);
    chk("t5_rst_ready", 32'(lsu_ready), 32'd1);
    chk("t5_rst_wren", 32'(wren), 32'd0);
    tick(); idle();
    lsu_valid = 1; lsu_waddr = 5'd0; lsu_wdata = 32'h55;
    tick(); idle();
    tick(); idle();
    @(negedge clk);
    chk("t5_r0_lsu", 32'(wren), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst          = ($urandom_range(0, 199) == 0);
      alu_valid    = (m_starve != 4) && ($urandom_range(0, 2) != 0);
      alu_waddr    = 5'($urandom_range(0, 7));
      alu_wdata    = $urandom;
      alu_is_upper = $urandom_range(0, 1) == 1;
      lsu_valid    = $urandom_range(0, 1) == 1;
      lsu_waddr    = 5'($urandom_range(0, 7));
      lsu_wdata    = $urandom;
      issue_valid  = $urandom_range(0, 1) == 1;
      issue_long   = $urandom_range(0, 1) == 1;
      issue_rd     = 5'($urandom_range(0, 7));
      raddr0       = 5'($urandom_range(0, 7));
      raddr1       = 5'($urandom_range(0, 7));
      rf_rdata0    = $urandom;
      rf_rdata1    = $urandom;
    end
    tick(); idle();
    repeat (12) tick();
    @(negedge clk);
    chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
